// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: walks the columns, freezes on a pressed key,
// feeds the debouncer with key_down and accepts one key per press from key_stb.
module keypad_scanner #(
   parameter int SCAN_DIV   = 1000,
   parameter int REL_CYCLES = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic       key_down,
   input  logic       key_stb,
   output logic [3:0] key_code,
   output logic       key_valid
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int RW = $clog2(REL_CYCLES + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
   localparam logic [RW-1:0] REL_MAX    = RW'(REL_CYCLES);
   localparam logic [RW-1:0] REL_ONE    = RW'(1);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      HOLD     = 2'd1,
      WAIT_REL = 2'd2
   } state_t;

   state_t        state_r;
   logic [3:0]    rows_meta_r;
   logic [3:0]    rows_s;
   logic [1:0]    col_idx_r;
   logic [1:0]    row_idx_r;
   logic [DW-1:0] dwell_r;
   logic [RW-1:0] rel_r;

   logic          row_hi_s;
   logic [RW-1:0] rel_next_s;
   logic          rel_hit_s;
   logic [2:0]    low_s;
   logic [1:0]    col_inc_s;

   // Returns {found, index} of the lowest-index low row line.
   function automatic logic [2:0] first_low(input logic [3:0] r);
      logic [2:0] res;
      res = 3'b000;
      if (r[0] == 1'b0) begin
         res = 3'b100;
      end else if (r[1] == 1'b0) begin
         res = 3'b101;
      end else if (r[2] == 1'b0) begin
         res = 3'b110;
      end else if (r[3] == 1'b0) begin
         res = 3'b111;
      end else begin
         res = 3'b000;
      end
      return res;
   endfunction

   // Two-flop synchronizer for the asynchronous row lines.
   always_ff @(posedge clk) begin
      if (rst) begin
         rows_meta_r <= 4'hF;
         rows_s      <= 4'hF;
      end else begin
         rows_meta_r <= rows;
         rows_s      <= rows_meta_r;
      end
   end

   // Release counter saturates at REL_CYCLES so a hit on the strobe-wins cycle is still seen in WAIT_REL.
   always_comb begin
      row_hi_s = rows_s[row_idx_r];
      if (row_hi_s == 1'b0) begin
         rel_next_s = '0;
      end else if (rel_r == REL_MAX) begin
         rel_next_s = REL_MAX;
      end else begin
         rel_next_s = rel_r + REL_ONE;
      end
      rel_hit_s = (rel_next_s == REL_MAX);
      low_s     = first_low(rows_s);
      col_inc_s = col_idx_r + 2'd1;
   end

   // Scan / hold / wait-for-release state machine with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= SCAN;
         col_idx_r <= 2'd0;
         row_idx_r <= 2'd0;
         cols      <= 4'b1110;
         dwell_r   <= '0;
         rel_r     <= '0;
         key_down  <= 1'b0;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         case (state_r)
            SCAN: begin
               key_down <= 1'b0;
               rel_r    <= '0;
               if (dwell_r == DWELL_LAST) begin
                  dwell_r <= '0;
                  if (low_s[2]) begin
                     row_idx_r <= low_s[1:0];
                     state_r   <= HOLD;
                  end else begin
                     col_idx_r <= col_inc_s;
                     cols      <= ~(4'b0001 << col_inc_s);
                  end
               end else begin
                  dwell_r <= dwell_r + DWELL_ONE;
               end
            end
            HOLD: begin
               // A strobe on the release-hit cycle still accepts the key.
               if (key_stb) begin
                  rel_r     <= rel_next_s;
                  key_down  <= ~row_hi_s;
                  key_code  <= {row_idx_r, col_idx_r};
                  key_valid <= 1'b1;
                  state_r   <= WAIT_REL;
               end else if (rel_hit_s) begin
                  rel_r     <= '0;
                  key_down  <= 1'b0;
                  col_idx_r <= col_inc_s;
                  cols      <= ~(4'b0001 << col_inc_s);
                  state_r   <= SCAN;
               end else begin
                  rel_r    <= rel_next_s;
                  key_down <= ~row_hi_s;
               end
            end
            WAIT_REL: begin
               if (rel_hit_s) begin
                  rel_r     <= '0;
                  key_down  <= 1'b0;
                  col_idx_r <= col_inc_s;
                  cols      <= ~(4'b0001 << col_inc_s);
                  state_r   <= SCAN;
               end else begin
                  rel_r    <= rel_next_s;
                  key_down <= ~row_hi_s;
               end
            end
            default: begin
               state_r   <= SCAN;
               col_idx_r <= 2'd0;
               cols      <= 4'b1110;
               dwell_r   <= '0;
               rel_r     <= '0;
               key_down  <= 1'b0;
            end
         endcase
      end
   end

endmodule
